// File: rtl/superscalar_pkg.sv
// Shared decode definitions for the two-wide RV32I integer core:
// opcode/funct constants, ALU operation encoding and the decoded-instruction record.
package superscalar_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
    } alu_op_t;

    typedef struct packed {
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        alu_op_t     alu_op;
        logic        use_imm;
        logic        writes_rd;
        logic        legal;
    } decoded_t;

    function automatic decoded_t decode(input logic [31:0] ins);
        decoded_t   d;
        logic [6:0] f7;
        logic [2:0] f3;
        f7 = ins[31:25];
        f3 = ins[14:12];
        d.rs1     = ins[19:15];
        d.rs2     = ins[24:20];
        d.rd      = ins[11:7];
        d.imm     = {{20{ins[31]}}, ins[31:20]};
        d.use_imm = 1'b1;
        d.legal   = 1'b0;
        case (f3)
            F3_ADD:  d.alu_op = ALU_ADD;
            F3_SLL:  d.alu_op = ALU_SLL;
            F3_SLT:  d.alu_op = ALU_SLT;
            F3_SLTU: d.alu_op = ALU_SLTU;
            F3_XOR:  d.alu_op = ALU_XOR;
            F3_SR:   d.alu_op = (f7 == F7_ALT) ? ALU_SRA : ALU_SRL;
            F3_OR:   d.alu_op = ALU_OR;
            default: d.alu_op = ALU_AND;
        endcase
        case (ins[6:0])
            OPC_OP: begin
                d.use_imm = 1'b0;
                d.legal   = (f7 == F7_BASE) || ((f7 == F7_ALT) && ((f3 == F3_ADD) || (f3 == F3_SR)));
                if ((f7 == F7_ALT) && (f3 == F3_ADD))
                    d.alu_op = ALU_SUB;
            end
            OPC_OP_IMM: begin
                // Only the shift-immediates constrain the upper bits
                if (f3 == F3_SLL)
                    d.legal = (f7 == F7_BASE);
                else if (f3 == F3_SR)
                    d.legal = (f7 == F7_BASE) || (f7 == F7_ALT);
                else
                    d.legal = 1'b1;
            end
            OPC_LUI: begin
                // LUI executes as x0 + upper immediate
                d.rs1    = 5'd0;
                d.imm    = {ins[31:12], 12'h000};
                d.alu_op = ALU_ADD;
                d.legal  = 1'b1;
            end
            default: d.legal = 1'b0;
        endcase
        d.writes_rd = d.legal;
        return d;
    endfunction

endpackage

// File: rtl/rv_alu.sv
// Combinational RV32I integer ALU; one instance per issue slot.
module rv_alu
    import superscalar_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  alu_op_t         alu_op,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic [XLEN-1:0] result
);

    always_comb begin
        result = '0;
        case (alu_op)
            ALU_ADD:  result = op_a + op_b;
            ALU_SUB:  result = op_a - op_b;
            ALU_SLL:  result = op_a << op_b[4:0];
            ALU_SLT:  result = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
            ALU_SLTU: result = {{(XLEN-1){1'b0}}, op_a < op_b};
            ALU_XOR:  result = op_a ^ op_b;
            ALU_SRL:  result = op_a >> op_b[4:0];
            ALU_SRA:  result = $signed(op_a) >>> op_b[4:0];
            ALU_OR:   result = op_a | op_b;
            ALU_AND:  result = op_a & op_b;
            default:  result = '0;
        endcase
    end

endmodule

// File: rtl/superscalar_core.sv
// Two-wide in-order RV32I execute slice: shared register file, same-cycle
// slot1->slot2 forwarding, registered writeback observation ports.
module superscalar_core
    import superscalar_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     instruction1,
    input  logic [31:0]     instruction2,
    input  logic            ins1_valid,
    input  logic            ins2_valid,
    output logic            wb1_valid,
    output logic [4:0]      wb1_rd,
    output logic [XLEN-1:0] wb1_data,
    output logic            wb2_valid,
    output logic [4:0]      wb2_rd,
    output logic [XLEN-1:0] wb2_data,
    output logic            illegal1,
    output logic            illegal2,
    output logic [31:0]     retired,
    input  logic [4:0]      dbg_addr,
    output logic [XLEN-1:0] dbg_data
);

    logic [XLEN-1:0] rf [NREGS];

    decoded_t        dec1, dec2;
    logic            exec1, exec2, wr1, wr2;
    logic [XLEN-1:0] rf1_a, rf1_b, rf2_a, rf2_b;
    logic [XLEN-1:0] src2_a, src2_b;
    logic [XLEN-1:0] op1_b, op2_b, result1, result2;

    logic            wb1_valid_reg, wb2_valid_reg, illegal1_reg, illegal2_reg;
    logic [4:0]      wb1_rd_reg, wb2_rd_reg;
    logic [XLEN-1:0] wb1_data_reg, wb2_data_reg;
    logic [31:0]     retired_reg;

    assign dec1  = decode(instruction1);
    assign dec2  = decode(instruction2);
    assign exec1 = ins1_valid & dec1.legal;
    assign exec2 = ins2_valid & dec2.legal;
    assign wr1   = exec1 & dec1.writes_rd & (dec1.rd != 5'd0);
    assign wr2   = exec2 & dec2.writes_rd & (dec2.rd != 5'd0);

    assign rf1_a = (dec1.rs1 == 5'd0) ? '0 : rf[dec1.rs1];
    assign rf1_b = (dec1.rs2 == 5'd0) ? '0 : rf[dec1.rs2];
    assign rf2_a = (dec2.rs1 == 5'd0) ? '0 : rf[dec2.rs1];
    assign rf2_b = (dec2.rs2 == 5'd0) ? '0 : rf[dec2.rs2];

    // wr1 already implies slot 1 is valid, legal and targets a non-zero rd
    assign src2_a = (wr1 && (dec1.rd == dec2.rs1)) ? result1 : rf2_a;
    assign src2_b = (wr1 && (dec1.rd == dec2.rs2)) ? result1 : rf2_b;

    assign op1_b = dec1.use_imm ? dec1.imm : rf1_b;
    assign op2_b = dec2.use_imm ? dec2.imm : src2_b;

    rv_alu #(.XLEN(XLEN)) u_alu1 (
        .alu_op (dec1.alu_op),
        .op_a   (rf1_a),
        .op_b   (op1_b),
        .result (result1)
    );

    rv_alu #(.XLEN(XLEN)) u_alu2 (
        .alu_op (dec2.alu_op),
        .op_a   (src2_a),
        .op_b   (op2_b),
        .result (result2)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++)
                rf[i] <= '0;
            wb1_valid_reg <= 1'b0;
            wb2_valid_reg <= 1'b0;
            wb1_rd_reg    <= '0;
            wb2_rd_reg    <= '0;
            wb1_data_reg  <= '0;
            wb2_data_reg  <= '0;
            illegal1_reg  <= 1'b0;
            illegal2_reg  <= 1'b0;
            retired_reg   <= '0;
        end else begin
            // Slot 2 is written last so it wins a same-rd collision
            if (wr1)
                rf[dec1.rd] <= result1;
            if (wr2)
                rf[dec2.rd] <= result2;
            wb1_valid_reg <= wr1;
            wb2_valid_reg <= wr2;
            if (wr1) begin
                wb1_rd_reg   <= dec1.rd;
                wb1_data_reg <= result1;
            end
            if (wr2) begin
                wb2_rd_reg   <= dec2.rd;
                wb2_data_reg <= result2;
            end
            illegal1_reg <= ins1_valid & ~dec1.legal;
            illegal2_reg <= ins2_valid & ~dec2.legal;
            retired_reg  <= retired_reg + 32'(exec1) + 32'(exec2);
        end
    end

    assign wb1_valid = wb1_valid_reg;
    assign wb1_rd    = wb1_rd_reg;
    assign wb1_data  = wb1_data_reg;
    assign wb2_valid = wb2_valid_reg;
    assign wb2_rd    = wb2_rd_reg;
    assign wb2_data  = wb2_data_reg;
    assign illegal1  = illegal1_reg;
    assign illegal2  = illegal2_reg;
    assign retired   = retired_reg;
    assign dbg_data  = (dbg_addr == 5'd0) ? '0 : rf[dbg_addr];

endmodule

// File: tb/tb_superscalar_core.sv
// Directed bench for superscalar_core: hand-computed expectations checked
// with immediate assertions after each issued pair.
module tb_superscalar_core;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instruction1, instruction2;
    logic        ins1_valid, ins2_valid;
    logic        wb1_valid, wb2_valid, illegal1, illegal2;
    logic [4:0]  wb1_rd, wb2_rd, dbg_addr;
    logic [31:0] wb1_data, wb2_data, retired, dbg_data;

    int checks = 0;
    int errors = 0;
    int step_no = 0;

    superscalar_core dut (
        .clk          (clk),
        .rst          (rst),
        .instruction1 (instruction1),
        .instruction2 (instruction2),
        .ins1_valid   (ins1_valid),
        .ins2_valid   (ins2_valid),
        .wb1_valid    (wb1_valid),
        .wb1_rd       (wb1_rd),
        .wb1_data     (wb1_data),
        .wb2_valid    (wb2_valid),
        .wb2_rd       (wb2_rd),
        .wb2_data     (wb2_data),
        .illegal1     (illegal1),
        .illegal2     (illegal2),
        .retired      (retired),
        .dbg_addr     (dbg_addr),
        .dbg_data     (dbg_data)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] i_type(input logic [11:0] imm, input logic [4:0] rs1,
                                           input logic [2:0] f3, input logic [4:0] rd);
        return {imm, rs1, f3, rd, 7'b0010011};
    endfunction

    function automatic logic [31:0] r_type(input logic [6:0] f7, input logic [4:0] rs2,
                                           input logic [4:0] rs1, input logic [2:0] f3,
                                           input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] lui(input logic [19:0] u, input logic [4:0] rd);
        return {u, rd, 7'b0110111};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic dbg(input logic [4:0] addr, input logic [31:0] exp);
        dbg_addr = addr;
        #1;
        chk($sformatf("dbg_x%0d", addr), dbg_data, exp);
    endtask

    task automatic step(input logic r, input logic v1, input logic [31:0] i1,
                        input logic v2, input logic [31:0] i2);
        @(negedge clk);
        rst = r; ins1_valid = v1; instruction1 = i1; ins2_valid = v2; instruction2 = i2;
        @(posedge clk);
        #1;
        step_no++;
        $display("step %0d rst=%0b s1=%0b:%h s2=%0b:%h -> wb1=%0b x%0d=%h wb2=%0b x%0d=%h ill=%0b%0b ret=%0d",
                 step_no, r, v1, i1, v2, i2, wb1_valid, wb1_rd, wb1_data,
                 wb2_valid, wb2_rd, wb2_data, illegal1, illegal2, retired);
    endtask

    initial begin
        rst = 1'b1; ins1_valid = 1'b0; ins2_valid = 1'b0;
        instruction1 = '0; instruction2 = '0; dbg_addr = '0;

        // Reset with a valid pair present: it must be discarded
        step(1'b1, 1'b1, i_type(12'd99, 5'd0, 3'b000, 5'd1), 1'b1, i_type(12'd98, 5'd0, 3'b000, 5'd2));
        step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        chk("rst_wb1_valid", {31'b0, wb1_valid}, 32'd0);
        chk("rst_wb2_valid", {31'b0, wb2_valid}, 32'd0);
        chk("rst_wb1_data", wb1_data, 32'd0);
        chk("rst_illegal", {30'b0, illegal1, illegal2}, 32'd0);
        chk("rst_retired", retired, 32'd0);
        dbg(5'd1, 32'd0);

        // ADDI x1,x0,5 / ADDI x2,x0,7
        step(1'b0, 1'b1, i_type(12'd5, 5'd0, 3'b000, 5'd1), 1'b1, i_type(12'd7, 5'd0, 3'b000, 5'd2));
        chk("p1_wb1_valid", {31'b0, wb1_valid}, 32'd1);
        chk("p1_wb1_rd", {27'b0, wb1_rd}, 32'd1);
        chk("p1_wb1_data", wb1_data, 32'd5);
        chk("p1_wb2_rd", {27'b0, wb2_rd}, 32'd2);
        chk("p1_wb2_data", wb2_data, 32'd7);
        chk("p1_retired", retired, 32'd2);
        dbg(5'd1, 32'd5);

        // ADDI x3,x0,10 / ADD x4,x3,x3 (forwarded)
        step(1'b0, 1'b1, i_type(12'd10, 5'd0, 3'b000, 5'd3), 1'b1, r_type(7'h00, 5'd3, 5'd3, 3'b000, 5'd4));
        chk("fwd_wb2_data", wb2_data, 32'd20);
        chk("fwd_retired", retired, 32'd4);
        dbg(5'd4, 32'd20);

        // WAW: ADDI x5,x0,1 / ADDI x5,x0,2
        step(1'b0, 1'b1, i_type(12'd1, 5'd0, 3'b000, 5'd5), 1'b1, i_type(12'd2, 5'd0, 3'b000, 5'd5));
        chk("waw_wb1_valid", {31'b0, wb1_valid}, 32'd1);
        chk("waw_wb2_valid", {31'b0, wb2_valid}, 32'd1);
        chk("waw_wb1_data", wb1_data, 32'd1);
        dbg(5'd5, 32'd2);

        // Both slots illegal: bad funct7 on SLL, and all-ones word
        step(1'b0, 1'b1, r_type(7'h20, 5'd2, 5'd1, 3'b001, 5'd15), 1'b1, 32'hFFFF_FFFF);
        chk("ill_illegal1", {31'b0, illegal1}, 32'd1);
        chk("ill_illegal2", {31'b0, illegal2}, 32'd1);
        chk("ill_wb1_valid", {31'b0, wb1_valid}, 32'd0);
        chk("ill_wb2_valid", {31'b0, wb2_valid}, 32'd0);
        chk("ill_retired", retired, 32'd6);
        dbg(5'd15, 32'd0);

        // ADDI x0,x1,9: legal, retires, writes nothing
        step(1'b0, 1'b1, i_type(12'd9, 5'd1, 3'b000, 5'd0), 1'b0, 32'h0);
        chk("x0_wb1_valid", {31'b0, wb1_valid}, 32'd0);
        chk("x0_illegal1", {31'b0, illegal1}, 32'd0);
        chk("x0_retired", retired, 32'd7);
        dbg(5'd0, 32'd0);

        // LUI x6,0x80000 / SRAI x7,x6,4 (forwarded)
        step(1'b0, 1'b1, lui(20'h80000, 5'd6), 1'b1, i_type(12'h404, 5'd6, 3'b101, 5'd7));
        chk("lui_wb1_data", wb1_data, 32'h8000_0000);
        chk("srai_wb2_data", wb2_data, 32'hF800_0000);
        chk("lui_retired", retired, 32'd9);

        // SLTU x8,x0,x6 / SLT x9,x6,x0
        step(1'b0, 1'b1, r_type(7'h00, 5'd6, 5'd0, 3'b011, 5'd8), 1'b1, r_type(7'h00, 5'd0, 5'd6, 3'b010, 5'd9));
        chk("sltu_wb1_data", wb1_data, 32'd1);
        chk("slt_wb2_data", wb2_data, 32'd1);

        // ADDI x10,x6,-1 / SLTIU x12,x0,-1
        step(1'b0, 1'b1, i_type(12'hFFF, 5'd6, 3'b000, 5'd10), 1'b1, i_type(12'hFFF, 5'd0, 3'b011, 5'd12));
        chk("addi_wrap_wb1_data", wb1_data, 32'h7FFF_FFFF);
        chk("sltiu_wb2_data", wb2_data, 32'd1);
        chk("wrap_retired", retired, 32'd13);

        // SUB x13,x1,x2 / XORI x14,x13,-1 (forwarded)
        step(1'b0, 1'b1, r_type(7'h20, 5'd2, 5'd1, 3'b000, 5'd13), 1'b1, i_type(12'hFFF, 5'd13, 3'b100, 5'd14));
        chk("sub_wb1_data", wb1_data, 32'hFFFF_FFFE);
        chk("xori_wb2_data", wb2_data, 32'd1);
        dbg(5'd13, 32'hFFFF_FFFE);

        // Idle cycle: valids drop, data holds
        step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        chk("idle_wb1_valid", {31'b0, wb1_valid}, 32'd0);
        chk("idle_wb2_valid", {31'b0, wb2_valid}, 32'd0);
        chk("idle_wb1_data_hold", wb1_data, 32'hFFFF_FFFE);
        chk("idle_illegal", {30'b0, illegal1, illegal2}, 32'd0);
        chk("idle_retired", retired, 32'd15);

        // Slot 2 only: ADDI x11,x0,3
        step(1'b0, 1'b0, 32'h0, 1'b1, i_type(12'd3, 5'd0, 3'b000, 5'd11));
        chk("s2only_wb1_valid", {31'b0, wb1_valid}, 32'd0);
        chk("s2only_wb2_rd", {27'b0, wb2_rd}, 32'd11);
        chk("s2only_wb2_data", wb2_data, 32'd3);
        chk("s2only_retired", retired, 32'd16);

        // Mid-stream reset discards the presented pair
        step(1'b1, 1'b1, i_type(12'd1, 5'd0, 3'b000, 5'd13), 1'b1, i_type(12'd2, 5'd0, 3'b000, 5'd16));
        chk("mrst_wb1_valid", {31'b0, wb1_valid}, 32'd0);
        chk("mrst_wb2_valid", {31'b0, wb2_valid}, 32'd0);
        chk("mrst_wb2_data", wb2_data, 32'd0);
        chk("mrst_wb2_rd", {27'b0, wb2_rd}, 32'd0);
        chk("mrst_retired", retired, 32'd0);
        dbg(5'd11, 32'd0);
        dbg(5'd6, 32'd0);
        dbg(5'd16, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
